// File: rtl/bist_sig_checker_if.sv
// Signature-checker bus: the BIST run stimulus/observation signals
// (valid, result, ready) flowing in, and the registered verdict flowing out.
//   master : drives valid/result/ready, observes the verdict (testbench / top wrapper)
//   slave  : the checker itself
interface bist_sig_checker_if #(
  parameter int WIDTH = 10
);
  logic             valid;
  logic [WIDTH-1:0] result;
  logic             ready;
  logic             done;
  logic             pass;
  logic             fail;
  logic [1:0]       err_code;
  logic [15:0]      sample_cnt;
  logic [WIDTH-1:0] last_sig;

  modport master (
    output valid, result, ready,
    input  done, pass, fail, err_code, sample_cnt, last_sig
  );

  modport slave (
    input  valid, result, ready,
    output done, pass, fail, err_code, sample_cnt, last_sig
  );
endinterface

// File: rtl/bist_sig_checker.sv
// bist_sig_checker: observer for the BIST adder top. Captures the last non-zero
// signature of a run, counts non-zero samples, and on the rising edge of
// ready compares the captured signature against GOLDEN_SIG. Aborted runs
// (valid dropped before ready) and hung runs (TIMEOUT cycles in RUN) also
// produce a failing verdict.
// Ports:
//   clk  - single clock, posedge
//   rst  - synchronous active-high reset
//   bus  - slave modport: valid/result/ready in; done/pass/fail/err_code/
//          sample_cnt/last_sig out (all registered, sticky until next run)
module bist_sig_checker #(
  parameter int               WIDTH      = 10,
  parameter logic [WIDTH-1:0] GOLDEN_SIG = 10'h2A5,
  parameter logic [15:0]      TIMEOUT    = 16'd4095
) (
  input logic               clk,
  input logic               rst,
  bist_sig_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  localparam logic [1:0] ERR_PASS     = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_ABORT    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  state_t           state, state_nxt;
  logic             ready_d;
  logic [15:0]      cyc_cnt, cyc_nxt;
  logic             done_r, done_nxt;
  logic             pass_r, pass_nxt;
  logic             fail_r, fail_nxt;
  logic [1:0]       err_r, err_nxt;
  logic [15:0]      cnt_r, cnt_nxt;
  logic [WIDTH-1:0] sig_r, sig_nxt;

  // A ready already high when RUN is entered is not a rise: ready_d tracks
  // ready in every state, so only a fresh 0->1 transition counts.
  logic ready_rise;
  assign ready_rise = bus.ready & ~ready_d;

  logic sig_match;
  assign sig_match = (sig_r == GOLDEN_SIG);

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    done_nxt  = done_r;
    pass_nxt  = pass_r;
    fail_nxt  = fail_r;
    err_nxt   = err_r;
    cnt_nxt   = cnt_r;
    sig_nxt   = sig_r;
    unique case (state)
      IDLE: begin
        // Previous verdict stays visible until a new run starts.
        if (bus.valid) begin
          state_nxt = RUN;
          cyc_nxt   = '0;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          fail_nxt  = 1'b0;
          err_nxt   = ERR_PASS;
          cnt_nxt   = '0;
          sig_nxt   = '0;
        end
      end
      RUN: begin
        cyc_nxt = cyc_cnt + 16'd1;
        // Capture also happens on the exit cycle (ready rise or timeout).
        if (bus.valid && (bus.result != '0)) begin
          sig_nxt = bus.result;
          if (cnt_r != 16'hFFFF) cnt_nxt = cnt_r + 16'd1;
        end
        if (ready_rise) begin
          state_nxt = CHECK;
        end else if (!bus.valid) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          fail_nxt  = 1'b1;
          err_nxt   = ERR_ABORT;
        end else if (cyc_cnt == TIMEOUT - 16'd1) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          fail_nxt  = 1'b1;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      CHECK: begin
        // sig_r already holds any sample taken on the ready-rise cycle.
        state_nxt = DONE;
        done_nxt  = 1'b1;
        pass_nxt  = sig_match;
        fail_nxt  = ~sig_match;
        err_nxt   = sig_match ? ERR_PASS : ERR_MISMATCH;
      end
      DONE: begin
        // valid must drop before another run can be armed.
        if (!bus.valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_d <= 1'b0;
      cyc_cnt <= '0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      fail_r  <= 1'b0;
      err_r   <= ERR_PASS;
      cnt_r   <= '0;
      sig_r   <= '0;
    end else begin
      state   <= state_nxt;
      ready_d <= bus.ready;
      cyc_cnt <= cyc_nxt;
      done_r  <= done_nxt;
      pass_r  <= pass_nxt;
      fail_r  <= fail_nxt;
      err_r   <= err_nxt;
      cnt_r   <= cnt_nxt;
      sig_r   <= sig_nxt;
    end
  end

  assign bus.done       = done_r;
  assign bus.pass       = pass_r;
  assign bus.fail       = fail_r;
  assign bus.err_code   = err_r;
  assign bus.sample_cnt = cnt_r;
  assign bus.last_sig   = sig_r;

endmodule
